shifter_pipe: RTL
=================

# shifter_pipe

Pipelined, parametrised barrel shifter with a valid/ready handshake on both sides. It supports logical, arithmetic and rotate modes in both directions, shift amounts up to and beyond the word width, and carry-out and zero flags. It processes one operation per cycle and sits between operand sources and the ALU result bus in the Arithmetic library. It is the registered, stall-able successor to the combinational shifter.

## Interface
- BitWidth, 8, data width; power of two, ≥ 4.
- ShiftWidth, $clog2(BitWidth), localparam; number of pipeline stages.
- Clk  input  1  clock; all state on rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- InValid  input  1  operation present on inputs.
- InReady  output  1  block accepts operation this cycle.
- Left  input  1  1 = shift/rotate left, 0 = right.
- Op  input  2  00 logical, 01 arithmetic, 10 rotate, 11 pass-through.
- dIN  input  BitWidth  operand.
- ShAmount  input  ShiftWidth+1  shift amount, 0..2·BitWidth−1.
- OutValid  output  1  result present on outputs.
- OutReady  input  1  consumer takes result this cycle.
- dOUT  output  BitWidth  result.
- CarryOut  output  1  last bit shifted out.
- ZeroOut  output  1  dOUT == 0.

## Operation
- Stage k (k = 0..ShiftWidth−1) conditionally shifts by 2^k under ShAmount[k]. Stage 0 is combinational on the inputs. Its result is captured into pipeline register 1. Register ShiftWidth drives the outputs.
- Sidecar per stage: valid bit, Left, Op, remaining amount bits, saturate flag, carry.
- Logical: vacated bits filled with 0.
- Arithmetic: right shift fills with dIN[BitWidth−1]. Left shift is identical to logical.
- Rotate: amount taken modulo BitWidth (ShAmount[ShiftWidth] ignored); no bits lost.
- Pass-through (Op=11): dOUT = dIN and CarryOut = 0, regardless of amount and Left.
- Saturation: logical/arithmetic with ShAmount ≥ BitWidth.
  - Logical result is 0.
  - Arithmetic right result is all sign bits; arithmetic left result is 0.
- CarryOut, logical/arithmetic, amount n:
  - n = 0 → 0.
  - 1 ≤ n ≤ BitWidth: left → dIN[BitWidth−n]; right → dIN[n−1].
  - n > BitWidth: left → 0; logical right → 0; arithmetic right → sign bit.
- CarryOut is 0 in rotate mode.
- ZeroOut is computed combinationally from dOUT and is qualified by OutValid.

## Timing
- Advance = !OutValid || OutReady. All stages move together on Advance and hold otherwise. Bubbles are not collapsed.
- InReady = Advance, combinational from OutValid/OutReady. There is no combinational path from InValid to InReady.
- Accept on a rising edge where InValid && InReady.
- An operation accepted at edge N appears with OutValid = 1 after edge N+ShiftWidth−1. For BitWidth = 8 this is two edges after acceptance.
- Throughput: one operation per cycle while OutReady = 1.
- When InValid = 0 at an advancing edge, a bubble (valid = 0) enters register 1.
- While OutValid && !OutReady, dOUT, CarryOut, ZeroOut and OutValid are held stable and no stage changes.
- Results leave in acceptance order, with no loss or duplication.
- Reset, asserted at any time including mid-stream:
  - All valid bits clear immediately; in-flight operations are discarded.
  - Result and sidecar registers go to 0, so dOUT = 0, CarryOut = 0, OutValid = 0.
  - ZeroOut = 1 (dOUT is 0).
  - InReady = 1.
- First accept is possible on the first rising edge after Rst deasserts.

## Test plan
All scenarios use BitWidth = 8.
- Reset: assert Rst with operations in flight → OutValid 0, dOUT 00, CarryOut 0, InReady 1 immediately. No stale result after Rst deasserts.
- Logical left, dIN=B5, ShAmount=3, accept at edge N → OutValid after edge N+2, dOUT=A8, CarryOut=1, ZeroOut=0.
- Arithmetic right: dIN=96, ShAmount=2 → E5, CarryOut=1. dIN=96, ShAmount=11 → FF, CarryOut=1.
- Rotate and saturation, each case checked against its expected result:
  - Rotate left, dIN=81, ShAmount=9 → 03, CarryOut=0.
  - Rotate right, dIN=81, ShAmount=1 → C0.
  - Logical right, dIN=FF, ShAmount=8 → 00, CarryOut=1, ZeroOut=1.
  - Logical right, ShAmount=12 → 00, CarryOut=0.
  - Pass-through, dIN=5A, ShAmount=5 → 5A.
- Backpressure: issue 5 back-to-back operations, then hold OutReady low for 4 cycles after the first OutValid → outputs stable and InReady=0 throughout. All 5 results arrive in order with no duplicates.
- Random streaming: random InValid/OutReady (50%) with 1000 random operations → every result matches a reference model, in order.

Source files
------------

// File: rtl/shifter_pipe.sv
// shifter_pipe: pipelined barrel shifter with valid/ready on both sides.
// Stage k shifts by 2^k when amount bit k is set. Saturated shifts
// (amount >= BitWidth) are resolved up front, so later stages only pass
// them through. All stages advance together when the output register is
// empty or being drained.
//
// Handshake: an operation is accepted on a rising edge where
// InValid && InReady; a result is taken on a rising edge where
// OutValid && OutReady. InReady depends only on OutValid/OutReady, and
// the outputs are held while OutValid && !OutReady.
module shifter_pipe #(
    parameter int BitWidth = 8,
    localparam int ShiftWidth = $clog2(BitWidth)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic                  Left,
    input  logic [1:0]            Op,
    input  logic [BitWidth-1:0]   dIN,
    input  logic [ShiftWidth:0]   ShAmount,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [BitWidth-1:0]   dOUT,
    output logic                  CarryOut,
    output logic                  ZeroOut
);

    localparam logic [1:0] OP_LOG  = 2'b00;
    localparam logic [1:0] OP_ARI  = 2'b01;
    localparam logic [1:0] OP_ROT  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    // Payload plus sidecar carried by every pipeline register.
    typedef struct packed {
        logic                valid;
        logic                left;
        logic [1:0]          op;
        logic [ShiftWidth:0] amt;
        logic                sat;
        logic                carry;
        logic [BitWidth-1:0] data;
    } stage_t;

    stage_t prep;
    stage_t pipe_d [1:ShiftWidth];
    stage_t pipe_q [1:ShiftWidth];
    logic   advance;

    // One conditional shift by 2^k. The carry of the last stage that
    // actually shifts equals the last bit shifted out of the whole word.
    function automatic stage_t shift_stage(input stage_t s, input int k);
        stage_t r;
        int     sh;
        r  = s;
        sh = 1 << k;
        if (s.amt[k]) begin
            case (s.op)
                OP_LOG, OP_ARI: begin
                    if (s.left) begin
                        r.data  = s.data << sh;
                        r.carry = s.data[BitWidth-sh];
                    end else begin
                        if (s.op == OP_ARI) r.data = $signed(s.data) >>> sh;
                        else                r.data = s.data >> sh;
                        r.carry = s.data[sh-1];
                    end
                end
                OP_ROT: begin
                    if (s.left) r.data = (s.data << sh) | (s.data >> (BitWidth - sh));
                    else        r.data = (s.data >> sh) | (s.data << (BitWidth - sh));
                end
                default: ;
            endcase
        end
        return r;
    endfunction

    assign advance = !pipe_q[ShiftWidth].valid || OutReady;
    assign InReady = advance;

    // Input conditioning: bubbles carry a zero payload, rotate ignores the
    // top amount bit, pass-through and saturated shifts are resolved here.
    always_comb begin
        prep = '0;
        if (InValid) begin
            prep.valid = 1'b1;
            prep.left  = Left;
            prep.op    = Op;
            prep.amt   = ShAmount;
            prep.data  = dIN;
            case (Op)
                OP_ROT:  prep.amt[ShiftWidth] = 1'b0;
                OP_PASS: prep.amt = '0;
                default: begin
                    if (ShAmount[ShiftWidth]) begin
                        prep.sat = 1'b1;
                        prep.amt = '0;
                        prep.data = (Op == OP_ARI && !Left) ? {BitWidth{dIN[BitWidth-1]}} : '0;
                        if (ShAmount[ShiftWidth-1:0] == '0)
                            prep.carry = Left ? dIN[0] : dIN[BitWidth-1];
                        else
                            prep.carry = (Op == OP_ARI && !Left) ? dIN[BitWidth-1] : 1'b0;
                    end
                end
            endcase
        end
    end

    // Next value of every pipeline register: stage 0 works on the inputs,
    // stage k on register k.
    always_comb begin
        pipe_d[1] = shift_stage(prep, 0);
        for (int k = 1; k < ShiftWidth; k++) begin
            pipe_d[k+1] = shift_stage(pipe_q[k], k);
        end
    end

    // Pipeline registers: all move together on advance, cleared by reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int k = 1; k <= ShiftWidth; k++) pipe_q[k] <= '0;
        end else if (advance) begin
            for (int k = 1; k <= ShiftWidth; k++) pipe_q[k] <= pipe_d[k];
        end
    end

    assign OutValid = pipe_q[ShiftWidth].valid;
    assign dOUT     = pipe_q[ShiftWidth].data;
    assign CarryOut = pipe_q[ShiftWidth].carry;
    assign ZeroOut  = (dOUT == '0);

endmodule
